// File: rtl/iomem_sample_fifo_pkg.sv
// iomem_sample_fifo shared definitions.
// Register selectors and STATUS/CONTROL/CLEAR bit positions.
package iomem_sample_fifo_pkg;

  typedef enum logic [1:0] {
    REG_DATA    = 2'd0,
    REG_STATUS  = 2'd1,
    REG_CONTROL = 2'd2,
    REG_CLEAR   = 2'd3
  } reg_sel_e;

  localparam int ST_EMPTY  = 16;
  localparam int ST_FULL   = 17;
  localparam int ST_OVF    = 18;
  localparam int CLR_OVF   = 18;
  localparam int CTL_FLUSH = 0;
  localparam int CTL_IRQEN = 1;

endpackage

// File: rtl/iomem_sample_fifo_if.sv
// iomem_sample_fifo bus + sample stream bundle.
// master: decoder/DSP side; slave: peripheral side.
interface iomem_sample_fifo_if #(
  parameter int WIDTH = 16
);
  logic             we;
  logic             re;
  logic [3:0]       addr;
  logic [31:0]      wdata;
  logic [3:0]       wstrb;
  logic [31:0]      rdata;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output we, re, addr, wdata, wstrb,
    output out_ready,
    input  rdata, out_data, out_valid
  );

  modport slave (
    input  we, re, addr, wdata, wstrb,
    input  out_ready,
    output rdata, out_data, out_valid
  );
endinterface

// File: rtl/iomem_sample_fifo_sync_fifo.sv
// Synchronous sample FIFO with flush and push-while-full-with-pop.
// Ports: ck/rst, push/pop/flush strobes, din/dout, count(+next), full/empty.
module sync_fifo #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  ck,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic [DEPTH_LOG2:0]   count,
  output logic [DEPTH_LOG2:0]   count_nxt,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT =
    (DEPTH_LOG2+1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, wr_nxt;
  logic [DEPTH_LOG2-1:0] rd_ptr, rd_nxt;
  logic                  do_pop, do_push;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a sample when the head leaves this cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_comb begin
    wr_nxt    = wr_ptr;
    rd_nxt    = rd_ptr;
    count_nxt = count;
    if (flush) begin
      wr_nxt    = '0;
      rd_nxt    = '0;
      count_nxt = '0;
    end else begin
      if (do_push)
        wr_nxt = wr_ptr + DEPTH_LOG2'(1);
      if (do_pop)
        rd_nxt = rd_ptr + DEPTH_LOG2'(1);
      if (do_push && !do_pop)
        count_nxt = count + 1'b1;
      else if (do_pop && !do_push)
        count_nxt = count - 1'b1;
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      count  <= count_nxt;
    end
  end

  always_ff @(posedge ck) begin
    if (!rst && !flush && do_push)
      mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/iomem_sample_fifo.sv
// CPU->DSP sample FIFO peripheral behind the iomem decoder.
// Ports: ck, rst, bus (slave: regs + sample stream), irq.
module iomem_sample_fifo
  import iomem_sample_fifo_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 4,
  parameter int THRESH_RST = 4
) (
  input  logic                 ck,
  input  logic                 rst,
  iomem_sample_fifo_if.slave   bus,
  output logic                 irq
);

  reg_sel_e              sel;
  logic                  wr_data, wr_ctl, wr_clr;
  logic                  rd_any;
  logic                  pop, flush;
  logic                  full, empty;
  logic [DEPTH_LOG2:0]   count, count_nxt;
  logic [WIDTH-1:0]      dout;
  logic                  ovf;
  logic                  irq_en, irq_en_nxt;
  logic [7:0]            thr, thr_nxt;
  logic [31:0]           status, rd_mux;
  logic                  unused;

  assign sel     = reg_sel_e'(bus.addr[3:2]);
  assign wr_data = bus.we && (sel == REG_DATA);
  assign wr_ctl  = bus.we && (sel == REG_CONTROL);
  assign wr_clr  = bus.we && (sel == REG_CLEAR);
  // we wins over a (never expected) simultaneous re
  assign rd_any  = bus.re && !bus.we;
  assign pop     = bus.out_valid && bus.out_ready;
  assign flush   = wr_ctl && bus.wstrb[0]
                 && bus.wdata[CTL_FLUSH];

  assign unused = ^{bus.addr[1:0], bus.wdata,
                    bus.wstrb[3:2]};

  sync_fifo #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .ck        (ck),
    .rst       (rst),
    .push      (wr_data),
    .pop       (pop),
    .flush     (flush),
    .din       (bus.wdata[WIDTH-1:0]),
    .dout      (dout),
    .count     (count),
    .count_nxt (count_nxt),
    .full      (full),
    .empty     (empty)
  );

  assign bus.out_data  = dout;
  assign bus.out_valid = !empty;

  always_ff @(posedge ck) begin
    if (rst)
      ovf <= 1'b0;
    else if (wr_data && full && !pop)
      ovf <= 1'b1;
    else if (wr_clr && bus.wdata[CLR_OVF])
      ovf <= 1'b0;
  end

  always_comb begin
    irq_en_nxt = irq_en;
    thr_nxt    = thr;
    if (wr_ctl && bus.wstrb[0])
      irq_en_nxt = bus.wdata[CTL_IRQEN];
    if (wr_ctl && bus.wstrb[1])
      thr_nxt = bus.wdata[15:8];
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      irq_en <= 1'b0;
      thr    <= 8'(THRESH_RST);
      irq    <= 1'b0;
    end else begin
      irq_en <= irq_en_nxt;
      thr    <= thr_nxt;
      // Uses post-update count and control so irq tracks this edge.
      irq    <= irq_en_nxt
             && (32'(count_nxt) <= 32'(thr_nxt));
    end
  end

  always_comb begin
    status                 = '0;
    status[DEPTH_LOG2:0]   = count;
    status[ST_EMPTY]       = empty;
    status[ST_FULL]        = full;
    status[ST_OVF]         = ovf;
  end

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      (sel == REG_STATUS):
        rd_mux = status;
      (sel == REG_CONTROL):
        rd_mux = {16'h0, thr, 6'h0, irq_en, 1'b0};
      default:
        rd_mux = '0;
    endcase
  end

  always_ff @(posedge ck) begin
    if (rst)
      bus.rdata <= '0;
    else if (rd_any)
      bus.rdata <= rd_mux;
  end

endmodule

// File: tb/tb_iomem_sample_fifo.sv
// Directed bench for iomem_sample_fifo.
// Linear steps; immediate assertions at each check.
module tb_iomem_sample_fifo;

  localparam logic [3:0] A_DATA = 4'h0;
  localparam logic [3:0] A_STAT = 4'h4;
  localparam logic [3:0] A_CTL  = 4'h8;
  localparam logic [3:0] A_CLR  = 4'hC;

  logic ck;
  logic rst;
  logic irq;
  int   n_vec;
  int   n_err;

  iomem_sample_fifo_if #(.WIDTH(16)) bus ();

  iomem_sample_fifo #(
    .WIDTH      (16),
    .DEPTH_LOG2 (4),
    .THRESH_RST (4)
  ) dut (
    .ck  (ck),
    .rst (rst),
    .bus (bus.slave),
    .irq (irq)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a,
                    input logic [31:0] d,
                    input logic [3:0] s);
    bus.we    = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    bus.wstrb = s;
    tick();
    bus.we    = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    bus.re   = 1'b1;
    bus.addr = a;
    tick();
    bus.re   = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.we = 1'b0;
    bus.re = 1'b0;
    bus.addr = '0;
    bus.wdata = '0;
    bus.wstrb = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // 1: reset state
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_valid", {31'h0, bus.out_valid}, 32'h0);
    rd(A_STAT);
    chk("rst_status", bus.rdata, 32'h0001_0000);
    rd(A_CTL);
    chk("rst_control", bus.rdata, 32'h0000_0400);

    // 2: push three, drain in order
    wr(A_DATA, 32'h1111, 4'hF);
    wr(A_DATA, 32'h2222, 4'hF);
    wr(A_DATA, 32'h3333, 4'hF);
    rd(A_STAT);
    chk("st3_status", bus.rdata, 32'h0000_0003);
    chk("st3_head", {16'h0, bus.out_data}, 32'h1111);
    bus.out_ready = 1'b1;
    chk("drain0", {16'h0, bus.out_data}, 32'h1111);
    tick();
    chk("drain1", {16'h0, bus.out_data}, 32'h2222);
    tick();
    chk("drain2", {16'h0, bus.out_data}, 32'h3333);
    tick();
    bus.out_ready = 1'b0;
    chk("drain_empty", {31'h0, bus.out_valid}, 32'h0);
    rd(A_STAT);
    chk("drain_status", bus.rdata, 32'h0001_0000);

    // 3: overfill
    for (int i = 0; i < 17; i++)
      wr(A_DATA, 32'h100 + i, 4'hF);
    rd(A_STAT);
    chk("ovf_status", bus.rdata, 32'h0006_0010);
    chk("ovf_head", {16'h0, bus.out_data}, 32'h0100);
    wr(A_CLR, 32'h0004_0000, 4'hF);
    rd(A_STAT);
    chk("clr_status", bus.rdata, 32'h0002_0010);

    // 4: push into full FIFO alongside a pop
    bus.out_ready = 1'b1;
    wr(A_DATA, 32'hABCD, 4'hF);
    bus.out_ready = 1'b0;
    rd(A_STAT);
    chk("fpp_status", bus.rdata, 32'h0002_0010);
    chk("fpp_head", {16'h0, bus.out_data}, 32'h0101);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("fpp_drain%0d", i),
          {16'h0, bus.out_data},
          (i < 15) ? 32'h101 + i : 32'hABCD);
      tick();
    end
    bus.out_ready = 1'b0;
    chk("fpp_empty", {31'h0, bus.out_valid}, 32'h0);

    // 5: low-water interrupt
    wr(A_CTL, 32'h0000_0202, 4'hF);
    chk("irq_cnt0", {31'h0, irq}, 32'h1);
    wr(A_DATA, 32'h5001, 4'hF);
    wr(A_DATA, 32'h5002, 4'hF);
    chk("irq_cnt2", {31'h0, irq}, 32'h1);
    wr(A_DATA, 32'h5003, 4'hF);
    chk("irq_cnt3", {31'h0, irq}, 32'h0);
    rd(A_CTL);
    chk("ctl_read", bus.rdata, 32'h0000_0202);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("irq_pop2", {31'h0, irq}, 32'h1);
    chk("irq_head", {16'h0, bus.out_data}, 32'h5002);
    wr(A_DATA, 32'h5004, 4'hF);
    chk("irq_push3", {31'h0, irq}, 32'h0);

    // 6: flush with concurrent ready
    wr(A_DATA, 32'h5005, 4'hF);
    wr(A_DATA, 32'h5006, 4'hF);
    rd(A_STAT);
    chk("fl_pre", bus.rdata, 32'h0000_0005);
    bus.out_ready = 1'b1;
    wr(A_CTL, 32'h0000_0203, 4'hF);
    bus.out_ready = 1'b0;
    chk("fl_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("fl_irq", {31'h0, irq}, 32'h1);
    rd(A_STAT);
    chk("fl_status", bus.rdata, 32'h0001_0000);
    tick();
    chk("rdata_hold", bus.rdata, 32'h0001_0000);

    // reset mid-stream
    wr(A_DATA, 32'h7001, 4'hF);
    wr(A_DATA, 32'h7002, 4'hF);
    rd(A_STAT);
    chk("mid_status", bus.rdata, 32'h0000_0002);
    rst = 1'b1;
    bus.we = 1'b1;
    bus.addr = A_DATA;
    bus.wdata = 32'h7003;
    bus.out_ready = 1'b1;
    tick();
    rst = 1'b0;
    bus.we = 1'b0;
    bus.out_ready = 1'b0;
    chk("mid_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("mid_irq", {31'h0, irq}, 32'h0);
    chk("mid_rdata", bus.rdata, 32'h0);
    rd(A_STAT);
    chk("mid_status2", bus.rdata, 32'h0001_0000);
    rd(A_CTL);
    chk("mid_control", bus.rdata, 32'h0000_0400);

    // byte-lane masking on CONTROL
    wr(A_CTL, 32'hFFFF_FF03, 4'b0010);
    rd(A_CTL);
    chk("lane_ctl", bus.rdata, 32'h0000_FF00);
    chk("lane_irq", {31'h0, irq}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
